// File: rtl/rose_resp_checker_if.sv
// Tap bundle for rose_resp_checker.
// master drives the observed signals; slave is the checker.
interface rose_resp_checker_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);
  logic              en;
  logic              clr;
  logic [NUM_CH-1:0] trig;
  logic [NUM_CH-1:0] resp;
  logic [NUM_CH-1:0] pass_o;
  logic [NUM_CH-1:0] fail_o;
  logic [NUM_CH-1:0] busy_o;
  logic [NUM_CH-1:0] overlap_err;
  logic [CNT_W-1:0]  pass_cnt;
  logic [CNT_W-1:0]  fail_cnt;

  modport master (
    output en, clr, trig, resp,
    input  pass_o, fail_o, busy_o,
    input  overlap_err, pass_cnt, fail_cnt
  );

  modport slave (
    input  en, clr, trig, resp,
    output pass_o, fail_o, busy_o,
    output overlap_err, pass_cnt, fail_cnt
  );
endinterface

// File: rtl/rose_resp_checker.sv
// Multi-channel "rise of trig |-> resp within [DLY_MIN:DLY_MAX]" checker.
// Observes only; all outputs are registered.
module rose_resp_checker #(
  parameter int NUM_CH  = 4,
  parameter int DLY_MIN = 10,
  parameter int DLY_MAX = 10,
  parameter int CNT_W   = 16
) (
  input logic clk,
  input logic rst,
  rose_resp_checker_if.slave bus
);

  localparam int CW = $clog2(DLY_MAX + 1);
  localparam int SW = CNT_W + $clog2(NUM_CH + 1);
  localparam logic [CW-1:0] MIN_C = CW'(DLY_MIN);
  localparam logic [CW-1:0] MAX_C = CW'(DLY_MAX);
  localparam logic [CNT_W-1:0] SAT = {CNT_W{1'b1}};

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t            st_q  [NUM_CH];
  logic [CW-1:0]     cnt_q [NUM_CH];
  logic [NUM_CH-1:0] trig_q;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] miss;
  logic [NUM_CH-1:0] busy_n;
  logic [NUM_CH-1:0] ovl_set;
  logic [NUM_CH-1:0] pass_q;
  logic [NUM_CH-1:0] fail_q;
  logic [NUM_CH-1:0] busy_q;
  logic [NUM_CH-1:0] ovl_q;
  logic [CNT_W-1:0]  pcnt_q;
  logic [CNT_W-1:0]  fcnt_q;

  function automatic logic [CNT_W-1:0] sat_add(
    input logic [CNT_W-1:0]  a,
    input logic [NUM_CH-1:0] v
  );
    logic [SW-1:0] s;
    s = SW'(a);
    for (int i = 0; i < NUM_CH; i++)
      s = s + SW'(v[i]);
    if (s > SW'(SAT))
      return SAT;
    return s[CNT_W-1:0];
  endfunction

  // Per-channel decisions for this edge: window hit, window expiry, next busy.
  always_comb begin
    rise    = bus.trig & ~trig_q;
    hit     = '0;
    miss    = '0;
    busy_n  = '0;
    ovl_set = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.en && st_q[i] == S_WAIT) begin
        ovl_set[i] = rise[i];
        if (cnt_q[i] >= MIN_C) begin
          hit[i]  = bus.resp[i];
          miss[i] = ~bus.resp[i] && (cnt_q[i] == MAX_C);
        end
        busy_n[i] = ~hit[i] & ~miss[i];
      end else if (bus.en) begin
        busy_n[i] = rise[i];
      end
    end
  end

  // Trig history tracks every cycle, independent of en.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      trig_q <= '0;
    else
      trig_q <= bus.trig;
  end

  // Channel FSMs with their registered pulse/busy outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        st_q[i]  <= S_IDLE;
        cnt_q[i] <= '0;
      end
      pass_q <= '0;
      fail_q <= '0;
      busy_q <= '0;
    end else begin
      pass_q <= hit;
      fail_q <= miss;
      busy_q <= busy_n;
      for (int i = 0; i < NUM_CH; i++) begin
        if (!bus.en) begin
          st_q[i]  <= S_IDLE;
          cnt_q[i] <= '0;
        end else begin
          unique case (st_q[i])
            S_IDLE: begin
              if (rise[i]) begin
                st_q[i]  <= S_WAIT;
                cnt_q[i] <= CW'(1);
              end
            end
            S_WAIT: begin
              if (hit[i] || miss[i]) begin
                st_q[i]  <= S_IDLE;
                cnt_q[i] <= '0;
              end else begin
                cnt_q[i] <= cnt_q[i] + CW'(1);
              end
            end
            default: begin
              st_q[i]  <= S_IDLE;
              cnt_q[i] <= '0;
            end
          endcase
        end
      end
    end
  end

  // Sticky overlap flags; clr has priority over a same-cycle set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ovl_q <= '0;
    else if (bus.clr)
      ovl_q <= '0;
    else
      ovl_q <= ovl_q | ovl_set;
  end

  // Saturating aggregate counters; a clr cycle drops its own results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q <= '0;
      fcnt_q <= '0;
    end else if (bus.clr) begin
      pcnt_q <= '0;
      fcnt_q <= '0;
    end else begin
      pcnt_q <= sat_add(pcnt_q, hit);
      fcnt_q <= sat_add(fcnt_q, miss);
    end
  end

  assign bus.pass_o      = pass_q;
  assign bus.fail_o      = fail_q;
  assign bus.busy_o      = busy_q;
  assign bus.overlap_err = ovl_q;
  assign bus.pass_cnt    = pcnt_q;
  assign bus.fail_cnt    = fcnt_q;

endmodule

// File: tb/tb_rose_resp_checker.sv
// Bench for rose_resp_checker: directed scenarios plus random
// traffic, all checked against a timestamp-based reference model.
module tb_rose_resp_checker;

  localparam int NC   = 4;
  localparam int DMIN = 3;
  localparam int DMAX = 6;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  rose_resp_checker_if #(.NUM_CH(NC), .CNT_W(CW)) bus ();

  rose_resp_checker #(
    .NUM_CH (NC),
    .DLY_MIN(DMIN),
    .DLY_MAX(DMAX),
    .CNT_W  (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  bit          act [NC];
  int          t0  [NC];
  logic [NC-1:0] mtq;
  logic [NC-1:0] m_pass;
  logic [NC-1:0] m_fail;
  logic [NC-1:0] m_ovl;
  int          m_pc;
  int          m_fc;
  int          n;
  logic [NC-1:0] cur_t;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      act[i] = 1'b0;
      t0[i]  = 0;
    end
    mtq    = '0;
    m_pass = '0;
    m_fail = '0;
    m_ovl  = '0;
    m_pc   = 0;
    m_fc   = 0;
  endtask

  // One clock edge of the rule set, using edge index n as time.
  task automatic model_edge(input logic [NC-1:0] t,
                            input logic [NC-1:0] r,
                            input logic e,
                            input logic c);
    for (int i = 0; i < NC; i++) begin
      logic rs;
      int   age;
      rs  = t[i] & ~mtq[i];
      age = n - t0[i];
      m_pass[i] = 1'b0;
      m_fail[i] = 1'b0;
      if (!e) begin
        act[i] = 1'b0;
      end else if (act[i]) begin
        if (rs) m_ovl[i] = 1'b1;
        if (age >= DMIN && r[i]) begin
          m_pass[i] = 1'b1;
          act[i]    = 1'b0;
        end else if (age == DMAX) begin
          m_fail[i] = 1'b1;
          act[i]    = 1'b0;
        end
      end else if (rs) begin
        act[i] = 1'b1;
        t0[i]  = n;
      end
    end
    mtq = t;
    if (c) begin
      m_ovl = '0;
      m_pc  = 0;
      m_fc  = 0;
    end else begin
      m_pc = m_pc + $countones(m_pass);
      m_fc = m_fc + $countones(m_fail);
      if (m_pc > CMAX) m_pc = CMAX;
      if (m_fc > CMAX) m_fc = CMAX;
    end
    n++;
  endtask

  task automatic compare();
    logic [NC-1:0] eb;
    for (int i = 0; i < NC; i++) eb[i] = act[i];
    check("pass_o", 32'(bus.pass_o), 32'(m_pass));
    check("fail_o", 32'(bus.fail_o), 32'(m_fail));
    check("busy_o", 32'(bus.busy_o), 32'(eb));
    check("overlap", 32'(bus.overlap_err), 32'(m_ovl));
    check("pass_cnt", 32'(bus.pass_cnt), 32'(m_pc));
    check("fail_cnt", 32'(bus.fail_cnt), 32'(m_fc));
  endtask

  task automatic step(input logic [NC-1:0] t,
                      input logic [NC-1:0] r,
                      input logic e,
                      input logic c);
    bus.trig = t;
    bus.resp = r;
    bus.en   = e;
    bus.clr  = c;
    cur_t    = t;
    @(posedge clk);
    model_edge(t, r, e, c);
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    model_reset();
    compare();
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    n        = 0;
    cur_t    = '0;
    bus.trig = '0;
    bus.resp = '0;
    bus.en   = 1'b0;
    bus.clr  = 1'b0;
    rst      = 1'b1;
    model_reset();
    @(negedge clk);
    check("rst_pass", 32'(bus.pass_o), 32'd0);
    check("rst_pcnt", 32'(bus.pass_cnt), 32'd0);
    check("rst_ovl", 32'(bus.overlap_err), 32'd0);
    compare();
    rst = 1'b0;

    // Window pass: resp at age 2 ignored, accepted at age 3.
    step(4'h1, 4'h0, 1, 0);
    check("d_busy", 32'(bus.busy_o), 32'h1);
    step(4'h1, 4'h0, 1, 0);
    step(4'h1, 4'h1, 1, 0);
    check("d_early", 32'(bus.pass_o), 32'h0);
    step(4'h1, 4'h1, 1, 0);
    check("d_pass", 32'(bus.pass_o), 32'h1);
    check("d_pcnt", 32'(bus.pass_cnt), 32'd1);

    // Window expiry: resp never comes, fail at age 6.
    step(4'h0, 4'h0, 1, 0);
    step(4'h1, 4'h0, 1, 0);
    for (int k = 1; k <= DMAX; k++) step(4'h1, 4'h0, 1, 0);
    check("d_fail", 32'(bus.fail_o), 32'h1);
    check("d_fcnt", 32'(bus.fail_cnt), 32'd1);

    // Overlap on channel 1, then clear.
    step(4'h0, 4'h0, 1, 0);
    step(4'h2, 4'h0, 1, 0);
    step(4'h0, 4'h0, 1, 0);
    step(4'h2, 4'h0, 1, 0);
    check("d_ovl", 32'(bus.overlap_err), 32'h2);
    for (int k = 0; k < DMAX; k++) step(4'h2, 4'h0, 1, 0);
    step(4'h0, 4'h0, 1, 1);
    check("d_ovl_clr", 32'(bus.overlap_err), 32'h0);

    // Mixed results on all channels in one cycle.
    step(4'hF, 4'h0, 1, 0);
    for (int k = 1; k < DMAX; k++) step(4'hF, 4'h0, 1, 0);
    step(4'hF, 4'h5, 1, 0);
    check("d_mix_p", 32'(bus.pass_o), 32'h5);
    check("d_mix_f", 32'(bus.fail_o), 32'hA);

    // Saturation of the pass counter.
    for (int j = 0; j < 5; j++) begin
      step(4'h0, 4'h0, 1, 0);
      step(4'hF, 4'h0, 1, 0);
      step(4'hF, 4'h0, 1, 0);
      step(4'hF, 4'h0, 1, 0);
      step(4'hF, 4'hF, 1, 0);
    end
    check("d_sat", 32'(bus.pass_cnt), 32'd15);

    // Disable mid-check drops it silently.
    step(4'h0, 4'h0, 1, 0);
    step(4'h1, 4'h0, 1, 0);
    step(4'h1, 4'h0, 1, 0);
    step(4'h1, 4'h0, 0, 0);
    check("d_en_busy", 32'(bus.busy_o), 32'h0);
    for (int k = 0; k < DMAX; k++) step(4'h1, 4'h1, 1, 0);

    // Async reset mid-check.
    step(4'h0, 4'h0, 1, 0);
    step(4'h3, 4'h0, 1, 0);
    step(4'h3, 4'h0, 1, 0);
    do_reset();

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      logic [NC-1:0] t;
      logic [NC-1:0] r;
      logic          e;
      logic          c;
      t = cur_t;
      for (int i = 0; i < NC; i++)
        if ($urandom_range(0, 6) == 0) t[i] = ~t[i];
      r = NC'($urandom) & NC'($urandom);
      e = ($urandom_range(0, 39) != 0);
      c = ($urandom_range(0, 29) == 0);
      step(t, r, e, c);
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
